// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle RISC-V style integer ALU with ready/valid handshakes.
//   Single-cycle ops (ADD/SUB/logic/SLT/SLTU) finish one cycle after acceptance.
//   Shifts move one bit per cycle. MUL (multiply-low) adds one multiplier bit per cycle.
// Ports:
//   CLK, RST_n            clock, async active-low reset
//   ALUOP, FUNCT3,
//   FUNCT7_5, FUNCT7_0    operation encoding
//   A, B                  operands (shift amount = B[log2(WIDTH)-1:0])
//   IN_VALID / IN_READY   request handshake (ready only in IDLE)
//   RESULT, ZERO, ILLEGAL registered result, zero flag, undefined-encoding flag
//   OUT_VALID / OUT_READY result handshake (result held until taken)
module alu_seq_unit #(
  parameter int WIDTH      = 32,
  parameter int ENABLE_MUL = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [1:0]       ALUOP,
  input  logic [2:0]       FUNCT3,
  input  logic             FUNCT7_5,
  input  logic             FUNCT7_0,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             ILLEGAL,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;  // counter must hold WIDTH for MUL

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d, dec_op;
  logic [WIDTH-1:0] opa_q, opa_d;   // shift operand / multiplicand
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier
  logic [WIDTH-1:0] acc_q, acc_d;   // partial product
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] alu_res, sh_step, acc_sum;
  logic [SHW-1:0]   shamt;

  assign shamt = B[SHW-1:0];

  // Instruction decode
  always_comb begin
    dec_op = OP_ADD;
    if (ALUOP == 2'b00) begin
      dec_op = OP_ADD;
    end else if (ALUOP == 2'b01) begin
      dec_op = OP_SUB;
    end else if (ALUOP == 2'b10 && FUNCT7_0) begin
      if (FUNCT3 == 3'b000 && ENABLE_MUL != 0) dec_op = OP_MUL;
      else                                     dec_op = OP_ILL;
    end else begin
      case (FUNCT3)
        3'b000: if (ALUOP == 2'b10 && FUNCT7_5) dec_op = OP_SUB;
                else                            dec_op = OP_ADD;
        3'b001: dec_op = OP_SLL;
        3'b010: dec_op = OP_SLT;
        3'b011: dec_op = OP_SLTU;
        3'b100: dec_op = OP_XOR;
        3'b101: if (FUNCT7_5) dec_op = OP_SRA;
                else          dec_op = OP_SRL;
        3'b110: dec_op = OP_OR;
        default: dec_op = OP_AND;
      endcase
    end
  end

  // Single-cycle result for ops that finish straight from IDLE
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  alu_res = A ^ B;
      OP_OR:   alu_res = A | B;
      OP_AND:  alu_res = A & B;
      default: alu_res = '0;
    endcase
  end

  // One shift step of the operand in flight
  always_comb begin
    sh_step = opa_q >> 1;
    case (op_q)
      OP_SLL:  sh_step = opa_q << 1;
      OP_SRA:  sh_step = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
      default: sh_step = opa_q >> 1;
    endcase
  end

  assign acc_sum = acc_q + (opb_q[0] ? opa_q : '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          op_d  = dec_op;
          ill_d = (dec_op == OP_ILL);
          case (dec_op)
            OP_ILL: begin
              res_d   = '0;
              state_d = S_DONE;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              // A zero shift amount has nothing to iterate, so it completes
              // at the same latency as the single-cycle ops.
              if (shamt == '0) begin
                res_d   = A;
                state_d = S_DONE;
              end else begin
                opa_d   = A;
                cnt_d   = CW'(shamt);
                state_d = S_SHIFT;
              end
            end
            OP_MUL: begin
              opa_d   = A;
              opb_d   = B;
              acc_d   = '0;
              cnt_d   = CW'(WIDTH);
              state_d = S_MUL;
            end
            default: begin
              res_d   = alu_res;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_SHIFT: begin
        opa_d = sh_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = sh_step;
          state_d = S_DONE;
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = acc_sum;
          state_d = S_DONE;
        end
      end
      default: begin  // S_DONE: hold result until consumer takes it
        if (OUT_READY) state_d = S_IDLE;
      end
    endcase
    zero_d = (res_d == '0);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b1;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign RESULT    = res_q;
  assign ZERO      = zero_q;
  assign ILLEGAL   = ill_q;

endmodule
